uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the Basys3 serial path. It replaces the fixed 8-bit, 9600-baud receiver and LED capture with a 16x oversampled receiver and a first-word-fall-through FIFO. Data width, parity mode, baud rate and buffer depth are all configurable. Each frame is stored together with its parity and framing error flags, so a consumer (LED display, command parser) can drain frames at its own pace.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate in bits per second
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 none, 1 even, 2 odd
FIFO_DEPTH, 16, FIFO entries; power of two, 2..256
Derived TICK_DIV = CLK_HZ/(BAUD*16), integer-truncated; 651 at the defaults.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
RsRx  in  1  serial line, idle high, asynchronous to clk
rd_en  in  1  pop the head entry; ignored when rd_valid=0
rd_data  out  DATA_BITS  head-entry payload, LSB received first
rd_perr  out  1  parity error flag of the head entry (0 when PARITY=0)
rd_ferr  out  1  framing error flag of the head entry (stop bit sampled 0)
rd_valid  out  1  FIFO not empty
full  out  1  FIFO holds FIFO_DEPTH entries
overflow  out  1  sticky: a frame arrived while full and was dropped
frame_cnt  out  8  count of frames written to the FIFO, wraps 255->0

Behaviour:
- Reset (async assert, sync release): FSM to IDLE, FIFO pointers and count to 0, all outputs 0, synchroniser flops to 1, tick and bit counters to 0.
- RsRx passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s.
- Tick generator: a free-running counter of 0..TICK_DIV-1 issues a 1-cycle tick on wrap. It runs continuously; only the sample counter resets per frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: falling level (rx_s=0) seen on a tick -> START, sample counter cleared.
- START: at 8 ticks (mid-bit), rx_s=0 -> DATA; rx_s=1 -> IDLE (glitch rejected, nothing written).
- DATA: sample every 16 ticks, shift in LSB first. After DATA_BITS samples -> PARITY if PARITY!=0, else -> STOP.
- PARITY: sample at 16 ticks. perr = (XOR of data bits ^ sampled bit) != (PARITY==2). That means even mode requires total ones to be even, odd mode requires an odd total.
- STOP: sample at 16 ticks; ferr = ~rx_s.
  - Frame write is pulsed the cycle after the stop sample; state -> IDLE the same cycle.
  - If rx_s=0 at stop (break or misframe), IDLE waits for rx_s=1 before accepting a new start.
- Write rule: write with full=0 stores {ferr, perr, data} and increments frame_cnt. Write with full=1 drops the frame, sets overflow, and leaves frame_cnt unchanged.
- Read rule: FWFT; rd_data/rd_perr/rd_ferr reflect the head whenever rd_valid=1. rd_en with rd_valid=1 advances the head on the next edge; rd_en with rd_valid=0 is a no-op.
- Simultaneous read and write:
  - When full: the pop frees a slot, the write succeeds, full stays 1, overflow is not set.
  - When empty: the read is ignored and the write succeeds.
- Latency: stop-bit mid-sample to rd_valid=1 is 2 clk cycles when the FIFO is empty.
- Pointers are log2(FIFO_DEPTH) bits, wrap naturally. Occupancy counter is log2(FIFO_DEPTH)+1 bits; full = (count==FIFO_DEPTH).
- overflow clears only on rst.
- Reset mid-frame abandons the partial frame and flushes the FIFO; no entry is produced.

Test Plan:
- Defaults, send 0x41 (8N1, 10416-clk bit period) -> rd_valid=1 within 2 clk of the stop sample, rd_data=0x41, perr=0, ferr=0, frame_cnt=1.
- PARITY=1: send 0x07 with parity bit 1 -> perr=0. Send 0x07 with parity bit 0 -> perr=1. Repeat with PARITY=2 -> flags inverted.
- Stop bit driven 0 on 0x55 -> entry stored with ferr=1. Line held low 3 frame times, then released -> no further entries until a valid start after idle.
- 0.3-bit low glitch on idle line -> no write, FSM back in IDLE, frame_cnt unchanged.
- FIFO_DEPTH=4, no reads, send 0x01..0x05:
  - full=1 after the 4th frame; the 5th is dropped and overflow=1.
  - Drain order 0x01..0x04, then rd_valid=0.
  - Refill to full, then pulse rd_en on the exact cycle of a 5th write -> accepted, overflow unchanged.
- DATA_BITS=7, assert rst mid-frame during bit 3, then send 0x2A -> only 0x2A present, frame_cnt=1. A further 256 frames -> frame_cnt wraps to 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 16x oversampled UART receiver feeding a first-word-fall-through FIFO.
// Each FIFO entry holds {framing error, parity error, payload}.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RsRx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_perr,
  output logic                 rd_ferr,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 overflow,
  output logic [7:0]           frame_cnt
);

  localparam int TICK_DIV = CLK_HZ / (BAUD * 16);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int EW       = DATA_BITS + 2;

  localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a low level on a tick (or for a break to end)
  // S_START  | start bit seen, confirm low at mid-bit
  // S_DATA   | sampling payload bits, LSB first
  // S_PARITY | sampling the parity bit
  // S_STOP   | sampling the stop bit, then request a FIFO write
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [TW-1:0]        r_tick_cnt;
  logic                 w_tick;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_smp_cnt;
  logic [3:0]           w_smp_nxt;
  logic [3:0]           r_bit_cnt;
  logic [3:0]           w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_perr;
  logic                 w_perr_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;
  logic                 r_brk;
  logic                 w_brk_nxt;
  logic                 r_wr;
  logic                 w_wr_nxt;
  logic                 w_mid_smp;
  logic                 w_last_smp;

  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_count;
  logic                 r_overflow;
  logic [7:0]           r_frame_cnt;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_do_rd;
  logic                 w_do_wr;
  logic [EW-1:0]        w_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RsRx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Free-running divider; the sample counter, not this, aligns to each frame.
  assign w_tick = (r_tick_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= TICK_LOAD;
    end else begin
      r_tick_cnt <= r_tick_cnt - TW'(1);
    end
  end

  assign w_mid_smp  = (r_smp_cnt == 4'd7);
  assign w_last_smp = (r_smp_cnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_smp_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_brk     <= 1'b0;
      r_wr      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_smp_cnt <= w_smp_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_perr    <= w_perr_nxt;
      r_ferr    <= w_ferr_nxt;
      r_brk     <= w_brk_nxt;
      r_wr      <= w_wr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_smp_nxt   = r_smp_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_ferr_nxt  = r_ferr;
    w_brk_nxt   = r_brk;
    w_wr_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // After a low stop bit the line must return high before a new start counts.
        if (r_brk) begin
          if (r_rx_s) w_brk_nxt = 1'b0;
        end else if (w_tick && !r_rx_s) begin
          w_state_nxt = S_START;
          w_smp_nxt   = '0;
          w_bit_nxt   = '0;
          w_perr_nxt  = 1'b0;
          w_ferr_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (w_mid_smp) begin
            w_smp_nxt   = '0;
            w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_smp_nxt = r_smp_cnt + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (w_last_smp) begin
            w_smp_nxt   = '0;
            w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == LAST_BIT) begin
              w_bit_nxt   = '0;
              w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + 4'd1;
            end
          end else begin
            w_smp_nxt = r_smp_cnt + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          if (w_last_smp) begin
            w_smp_nxt   = '0;
            w_perr_nxt  = (^r_shift) ^ r_rx_s ^ (PARITY == 2);
            w_state_nxt = S_STOP;
          end else begin
            w_smp_nxt = r_smp_cnt + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (w_last_smp) begin
            w_smp_nxt   = '0;
            w_ferr_nxt  = ~r_rx_s;
            w_brk_nxt   = ~r_rx_s;
            w_wr_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_smp_nxt = r_smp_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_do_rd = rd_en & ~w_empty;
  // A pop in the same cycle frees the slot the incoming frame needs.
  assign w_do_wr = r_wr & (~w_full | w_do_rd);

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= {r_ferr, r_perr, r_shift};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_do_wr) begin
        r_wptr      <= r_wptr + AW'(1);
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if (w_do_rd) r_rptr <= r_rptr + AW'(1);
      if (r_wr && !w_do_wr) r_overflow <= 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is masked while empty so stale or uninitialised storage never shows.
  assign w_head    = r_mem[r_rptr];
  assign rd_valid  = ~w_empty;
  assign rd_data   = rd_valid ? w_head[DATA_BITS-1:0] : '0;
  assign rd_perr   = rd_valid & w_head[DATA_BITS];
  assign rd_ferr   = rd_valid & w_head[DATA_BITS+1];
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: four instances cover 8N1/depth 4, even and
// odd parity sharing one line, and 7N1/depth 16 for reset and counter wrap.
module tb_uart_rx_fifo;

  localparam int BCLK_A = 48;
  localparam int BCLK_F = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_7;
  logic rx_a, rx_p, rx_7;
  logic rd_en_a, rd_en_e, rd_en_o, rd_en_7;

  logic [7:0] rd_data_a, rd_data_e, rd_data_o;
  logic [6:0] rd_data_7;
  logic rd_perr_a, rd_ferr_a, rd_valid_a, full_a, overflow_a;
  logic rd_perr_e, rd_ferr_e, rd_valid_e, full_e, overflow_e;
  logic rd_perr_o, rd_ferr_o, rd_valid_o, full_o, overflow_o;
  logic rd_perr_7, rd_ferr_7, rd_valid_7, full_7, overflow_7;
  logic [7:0] frame_cnt_a, frame_cnt_e, frame_cnt_o, frame_cnt_7;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic fbits[$];

  uart_rx_fifo #(.CLK_HZ(4_800_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .RsRx(rx_a), .rd_en(rd_en_a), .rd_data(rd_data_a), .rd_perr(rd_perr_a),
    .rd_ferr(rd_ferr_a), .rd_valid(rd_valid_a), .full(full_a), .overflow(overflow_a), .frame_cnt(frame_cnt_a));

  uart_rx_fifo #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .rst(rst), .RsRx(rx_p), .rd_en(rd_en_e), .rd_data(rd_data_e), .rd_perr(rd_perr_e),
    .rd_ferr(rd_ferr_e), .rd_valid(rd_valid_e), .full(full_e), .overflow(overflow_e), .frame_cnt(frame_cnt_e));

  uart_rx_fifo #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) u_o (
    .clk(clk), .rst(rst), .RsRx(rx_p), .rd_en(rd_en_o), .rd_data(rd_data_o), .rd_perr(rd_perr_o),
    .rd_ferr(rd_ferr_o), .rd_valid(rd_valid_o), .full(full_o), .overflow(overflow_o), .frame_cnt(frame_cnt_o));

  uart_rx_fifo #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(0), .FIFO_DEPTH(16)) u_7 (
    .clk(clk), .rst(rst_7), .RsRx(rx_7), .rd_en(rd_en_7), .rd_data(rd_data_7), .rd_perr(rd_perr_7),
    .rd_ferr(rd_ferr_7), .rd_valid(rd_valid_7), .full(full_7), .overflow(overflow_7), .frame_cnt(frame_cnt_7));

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_p = v;
      default: rx_7 = v;
    endcase
  endtask

  task automatic mk_frame(input logic [8:0] d, input int nb, input bit pen, input logic pb, input logic sb);
    logic [8:0] t;
    t = d;
    fbits.delete();
    fbits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      fbits.push_back(t[0]);
      t = t >> 1;
    end
    if (pen) fbits.push_back(pb);
    fbits.push_back(sb);
  endtask

  task automatic drive_bits(input int sel, input int first, input int last, input int bclk);
    for (int i = first; i <= last; i++) begin
      set_line(sel, fbits[i]);
      repeat (bclk) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input int nb, input bit pen,
                            input logic pb, input logic sb, input int bclk);
    mk_frame(d, nb, pen, pb, sb);
    drive_bits(sel, 0, fbits.size() - 1, bclk);
  endtask

  task automatic idle(input int sel, input int nbits, input int bclk);
    set_line(sel, 1'b1);
    repeat (nbits * bclk) @(negedge clk);
  endtask

  task automatic pop(input int sel);
    case (sel)
      0:       rd_en_a = 1'b1;
      1:       begin rd_en_e = 1'b1; rd_en_o = 1'b1; end
      default: rd_en_7 = 1'b1;
    endcase
    @(negedge clk);
    rd_en_a = 1'b0; rd_en_e = 1'b0; rd_en_o = 1'b0; rd_en_7 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst_7 = 1'b1;
    rx_a = 1'b1; rx_p = 1'b1; rx_7 = 1'b1;
    rd_en_a = 1'b0; rd_en_e = 1'b0; rd_en_o = 1'b0; rd_en_7 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0; rst_7 = 1'b0;
    repeat (2) @(negedge clk);
    tot_cnt++; if ({rd_valid_a, full_a, overflow_a, rd_perr_a, rd_ferr_a} !== 5'b0) $display("FAIL reset_flags_a: got %b want 00000", {rd_valid_a, full_a, overflow_a, rd_perr_a, rd_ferr_a}); else pass_cnt++;
    tot_cnt++; if (rd_data_a !== 8'h00) $display("FAIL reset_data_a: got %h want 00", rd_data_a); else pass_cnt++;
    tot_cnt++; if (frame_cnt_a !== 8'd0) $display("FAIL reset_cnt_a: got %0d want 0", frame_cnt_a); else pass_cnt++;
    tot_cnt++; if ({rd_valid_e, full_e, overflow_e, rd_perr_e, rd_ferr_e} !== 5'b0) $display("FAIL reset_flags_e: got %b want 00000", {rd_valid_e, full_e, overflow_e, rd_perr_e, rd_ferr_e}); else pass_cnt++;
    tot_cnt++; if ({rd_data_e, frame_cnt_e} !== 16'h0) $display("FAIL reset_data_e: got %h want 0000", {rd_data_e, frame_cnt_e}); else pass_cnt++;
    tot_cnt++; if ({rd_valid_o, full_o, overflow_o, rd_perr_o, rd_ferr_o} !== 5'b0) $display("FAIL reset_flags_o: got %b want 00000", {rd_valid_o, full_o, overflow_o, rd_perr_o, rd_ferr_o}); else pass_cnt++;
    tot_cnt++; if ({rd_data_o, frame_cnt_o} !== 16'h0) $display("FAIL reset_data_o: got %h want 0000", {rd_data_o, frame_cnt_o}); else pass_cnt++;
    tot_cnt++; if ({rd_valid_7, full_7, overflow_7, rd_perr_7, rd_ferr_7} !== 5'b0) $display("FAIL reset_flags_7: got %b want 00000", {rd_valid_7, full_7, overflow_7, rd_perr_7, rd_ferr_7}); else pass_cnt++;
    tot_cnt++; if ({rd_data_7, frame_cnt_7} !== 15'h0) $display("FAIL reset_data_7: got %h want 0000", {rd_data_7, frame_cnt_7}); else pass_cnt++;
  endtask

  task automatic test_basic;
    int cyc;
    mk_frame(9'h041, 8, 1'b0, 1'b0, 1'b1);
    drive_bits(0, 0, 8, BCLK_A);
    set_line(0, 1'b1);
    tot_cnt++; if (rd_valid_a !== 1'b0) $display("FAIL basic_early: rd_valid %b want 0 at stop-bit start", rd_valid_a); else pass_cnt++;
    cyc = 0;
    while (rd_valid_a !== 1'b1 && cyc < BCLK_A) begin
      @(negedge clk);
      cyc++;
    end
    tot_cnt++; if (rd_valid_a !== 1'b1) $display("FAIL basic_valid: rd_valid %b want 1 within stop bit", rd_valid_a); else pass_cnt++;
    tot_cnt++; if (rd_data_a !== 8'h41) $display("FAIL basic_data: got %h want 41", rd_data_a); else pass_cnt++;
    tot_cnt++; if ({rd_perr_a, rd_ferr_a} !== 2'b00) $display("FAIL basic_flags: got %b want 00", {rd_perr_a, rd_ferr_a}); else pass_cnt++;
    tot_cnt++; if (frame_cnt_a !== 8'd1) $display("FAIL basic_cnt: got %0d want 1", frame_cnt_a); else pass_cnt++;
    idle(0, 1, BCLK_A);
    pop(0);
    tot_cnt++; if (rd_valid_a !== 1'b0) $display("FAIL basic_pop: rd_valid %b want 0", rd_valid_a); else pass_cnt++;
  endtask

  task automatic test_parity;
    send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1'b1, BCLK_F);
    idle(1, 1, BCLK_F);
    tot_cnt++; if ({rd_valid_e, rd_data_e} !== 9'h107) $display("FAIL par1_even_data: got %h want 107", {rd_valid_e, rd_data_e}); else pass_cnt++;
    tot_cnt++; if ({rd_perr_e, rd_ferr_e} !== 2'b00) $display("FAIL par1_even_flags: got %b want 00", {rd_perr_e, rd_ferr_e}); else pass_cnt++;
    tot_cnt++; if ({rd_valid_o, rd_data_o} !== 9'h107) $display("FAIL par1_odd_data: got %h want 107", {rd_valid_o, rd_data_o}); else pass_cnt++;
    tot_cnt++; if ({rd_perr_o, rd_ferr_o} !== 2'b10) $display("FAIL par1_odd_flags: got %b want 10", {rd_perr_o, rd_ferr_o}); else pass_cnt++;
    pop(1);
    send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1'b1, BCLK_F);
    idle(1, 1, BCLK_F);
    tot_cnt++; if ({rd_perr_e, rd_ferr_e} !== 2'b10) $display("FAIL par0_even_flags: got %b want 10", {rd_perr_e, rd_ferr_e}); else pass_cnt++;
    tot_cnt++; if ({rd_perr_o, rd_ferr_o} !== 2'b00) $display("FAIL par0_odd_flags: got %b want 00", {rd_perr_o, rd_ferr_o}); else pass_cnt++;
    tot_cnt++; if ({frame_cnt_e, frame_cnt_o} !== 16'h0202) $display("FAIL par_cnt: got %h want 0202", {frame_cnt_e, frame_cnt_o}); else pass_cnt++;
    pop(1);
    tot_cnt++; if ({rd_valid_e, rd_valid_o, full_e, full_o, overflow_e, overflow_o} !== 6'b0) $display("FAIL par_drain: got %b want 000000", {rd_valid_e, rd_valid_o, full_e, full_o, overflow_e, overflow_o}); else pass_cnt++;
  endtask

  task automatic test_framing;
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b0, BCLK_A);
    repeat (30 * BCLK_A) @(negedge clk);
    idle(0, 2, BCLK_A);
    tot_cnt++; if (frame_cnt_a !== 8'd2) $display("FAIL brk_cnt: got %0d want 2", frame_cnt_a); else pass_cnt++;
    tot_cnt++; if ({rd_valid_a, rd_data_a} !== 9'h155) $display("FAIL brk_data: got %h want 155", {rd_valid_a, rd_data_a}); else pass_cnt++;
    tot_cnt++; if ({rd_ferr_a, rd_perr_a} !== 2'b10) $display("FAIL brk_ferr: got %b want 10", {rd_ferr_a, rd_perr_a}); else pass_cnt++;
    pop(0);
    tot_cnt++; if (rd_valid_a !== 1'b0) $display("FAIL brk_only_one: rd_valid %b want 0", rd_valid_a); else pass_cnt++;
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, BCLK_A);
    idle(0, 1, BCLK_A);
    tot_cnt++; if ({rd_valid_a, rd_ferr_a, rd_data_a} !== 10'h23C) $display("FAIL brk_recover: got %h want 23c", {rd_valid_a, rd_ferr_a, rd_data_a}); else pass_cnt++;
    tot_cnt++; if (frame_cnt_a !== 8'd3) $display("FAIL brk_recover_cnt: got %0d want 3", frame_cnt_a); else pass_cnt++;
    pop(0);
  endtask

  task automatic test_glitch;
    set_line(0, 1'b0);
    repeat (14) @(negedge clk);
    idle(0, 3, BCLK_A);
    tot_cnt++; if (rd_valid_a !== 1'b0) $display("FAIL glitch_nowrite: rd_valid %b want 0", rd_valid_a); else pass_cnt++;
    tot_cnt++; if (frame_cnt_a !== 8'd3) $display("FAIL glitch_cnt: got %0d want 3", frame_cnt_a); else pass_cnt++;
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, BCLK_A);
    idle(0, 1, BCLK_A);
    tot_cnt++; if ({rd_valid_a, rd_data_a} !== 9'h1A5) $display("FAIL glitch_next: got %h want 1a5", {rd_valid_a, rd_data_a}); else pass_cnt++;
    pop(0);
  endtask

  task automatic test_fifo_full;
    int cyc;
    for (int v = 1; v <= 5; v++) begin
      send_frame(0, 9'(v), 8, 1'b0, 1'b0, 1'b1, BCLK_A);
      idle(0, 1, BCLK_A);
      if (v == 3) begin
        tot_cnt++; if (full_a !== 1'b0) $display("FAIL fill3_full: got %b want 0", full_a); else pass_cnt++;
      end
      if (v == 4) begin
        tot_cnt++; if ({full_a, overflow_a} !== 2'b10) $display("FAIL fill4_flags: got %b want 10", {full_a, overflow_a}); else pass_cnt++;
        tot_cnt++; if (frame_cnt_a !== 8'd8) $display("FAIL fill4_cnt: got %0d want 8", frame_cnt_a); else pass_cnt++;
      end
      if (v == 5) begin
        tot_cnt++; if ({full_a, overflow_a} !== 2'b11) $display("FAIL drop_flags: got %b want 11", {full_a, overflow_a}); else pass_cnt++;
        tot_cnt++; if (frame_cnt_a !== 8'd8) $display("FAIL drop_cnt: got %0d want 8", frame_cnt_a); else pass_cnt++;
      end
    end
    for (int v = 1; v <= 4; v++) begin
      tot_cnt++; if ({rd_valid_a, rd_data_a} !== 9'(256 + v)) $display("FAIL drain_order: got %h want %h", {rd_valid_a, rd_data_a}, 9'(256 + v)); else pass_cnt++;
      pop(0);
    end
    tot_cnt++; if ({rd_valid_a, full_a} !== 2'b00) $display("FAIL drain_empty: got %b want 00", {rd_valid_a, full_a}); else pass_cnt++;
    for (int v = 8'h11; v <= 8'h14; v++) begin
      send_frame(0, 9'(v), 8, 1'b0, 1'b0, 1'b1, BCLK_A);
      idle(0, 1, BCLK_A);
    end
    tot_cnt++; if ({full_a, frame_cnt_a} !== 9'h10C) $display("FAIL refill: got %h want 10c", {full_a, frame_cnt_a}); else pass_cnt++;
    mk_frame(9'h015, 8, 1'b0, 1'b0, 1'b1);
    drive_bits(0, 0, 8, BCLK_A);
    set_line(0, 1'b1);
    cyc = 0;
    while (u_a.r_wr !== 1'b1 && cyc < BCLK_A) begin
      @(negedge clk);
      cyc++;
    end
    tot_cnt++; if (u_a.r_wr !== 1'b1) $display("FAIL rw_timeout: write strobe %b want 1 within stop bit", u_a.r_wr); else pass_cnt++;
    rd_en_a = 1'b1;
    @(negedge clk);
    rd_en_a = 1'b0;
    idle(0, 1, BCLK_A);
    tot_cnt++; if ({full_a, overflow_a, frame_cnt_a} !== 10'h30D) $display("FAIL rw_full: got %h want 30d", {full_a, overflow_a, frame_cnt_a}); else pass_cnt++;
    for (int v = 8'h12; v <= 8'h15; v++) begin
      tot_cnt++; if ({rd_valid_a, rd_data_a} !== 9'(256 + v)) $display("FAIL rw_order: got %h want %h", {rd_valid_a, rd_data_a}, 9'(256 + v)); else pass_cnt++;
      pop(0);
    end
    tot_cnt++; if (rd_valid_a !== 1'b0) $display("FAIL rw_empty: rd_valid %b want 0", rd_valid_a); else pass_cnt++;
  endtask

  task automatic test_midframe_rst;
    send_frame(2, 9'h011, 7, 1'b0, 1'b0, 1'b1, BCLK_F);
    idle(2, 1, BCLK_F);
    tot_cnt++; if ({rd_valid_7, rd_data_7} !== 8'h91) $display("FAIL pre_rst: got %h want 91", {rd_valid_7, rd_data_7}); else pass_cnt++;
    mk_frame(9'h055, 7, 1'b0, 1'b0, 1'b1);
    drive_bits(2, 0, 3, BCLK_F);
    set_line(2, fbits[4]);
    repeat (BCLK_F / 2) @(negedge clk);
    rst_7 = 1'b1;
    set_line(2, 1'b1);
    repeat (3) @(negedge clk);
    rst_7 = 1'b0;
    idle(2, 12, BCLK_F);
    tot_cnt++; if ({rd_valid_7, frame_cnt_7} !== 9'h000) $display("FAIL rst_flush: got %h want 000", {rd_valid_7, frame_cnt_7}); else pass_cnt++;
    send_frame(2, 9'h02A, 7, 1'b0, 1'b0, 1'b1, BCLK_F);
    idle(2, 1, BCLK_F);
    tot_cnt++; if ({rd_valid_7, rd_data_7} !== 8'hAA) $display("FAIL post_rst_data: got %h want aa", {rd_valid_7, rd_data_7}); else pass_cnt++;
    tot_cnt++; if (frame_cnt_7 !== 8'd1) $display("FAIL post_rst_cnt: got %0d want 1", frame_cnt_7); else pass_cnt++;
    pop(2);
    tot_cnt++; if (rd_valid_7 !== 1'b0) $display("FAIL post_rst_only: rd_valid %b want 0", rd_valid_7); else pass_cnt++;
  endtask

  task automatic test_cnt_wrap;
    rd_en_7 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send_frame(2, 9'(i & 127), 7, 1'b0, 1'b0, 1'b1, BCLK_F);
      idle(2, 1, BCLK_F);
      if (i == 254) begin
        tot_cnt++; if (frame_cnt_7 !== 8'd0) $display("FAIL wrap_zero: got %0d want 0", frame_cnt_7); else pass_cnt++;
      end
    end
    rd_en_7 = 1'b0;
    @(negedge clk);
    tot_cnt++; if (frame_cnt_7 !== 8'd1) $display("FAIL wrap_one: got %0d want 1", frame_cnt_7); else pass_cnt++;
    tot_cnt++; if ({rd_valid_7, full_7, overflow_7, rd_perr_7, rd_ferr_7} !== 5'b0) $display("FAIL wrap_flags: got %b want 00000", {rd_valid_7, full_7, overflow_7, rd_perr_7, rd_ferr_7}); else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_fifo_full();
    test_midframe_rst();
    test_cnt_wrap();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
